// File: rtl/mfp_io_debounce_pkg.sv
// Shared constants and per-bit update decode for the board input debouncer.
// Optional edge pulses are built only when MFP_DEBOUNCE_EDGE_EN is defined.
package mfp_io_debounce_pkg;

    localparam int unsigned MFP_N_SW              = 16;
    localparam int unsigned MFP_N_PB              = 5;
    localparam int unsigned MFP_DEBOUNCE_TICK_DIV = 50000;
    localparam int unsigned MFP_DEBOUNCE_STABLE   = 10;

    typedef enum logic [1:0] {
        ACT_CLEAR,
        ACT_HOLD,
        ACT_COUNT,
        ACT_FLIP
    } db_act_e;

    // Agreement always clears progress; counting advances only on a tick.
    function automatic db_act_e db_action(input logic eq, input logic tick, input logic at_last);
        db_act_e act;
        act = ACT_HOLD;
        if (eq)
            act = ACT_CLEAR;
        else if (tick)
            act = at_last ? ACT_FLIP : ACT_COUNT;
        return act;
    endfunction

endpackage

// File: rtl/mfp_debounce_bit.sv
// One debounced input: 2-flop synchroniser, stability counter, level, edge pulses.
// Edge pulse registers exist only with MFP_DEBOUNCE_EDGE_EN defined.
module mfp_debounce_bit
    import mfp_io_debounce_pkg::*;
#(
    parameter int unsigned STABLE_TICKS = MFP_DEBOUNCE_STABLE
) (
    input  logic HCLK,
    input  logic HRESETn,
    input  logic i_tick,
    input  logic i_raw,
    output logic o_db,
    output logic o_rise,
    output logic o_fall
);

    localparam int unsigned CW = $clog2(STABLE_TICKS + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_db;
    logic [CW-1:0] r_cnt;
    db_act_e       w_act;

    assign w_act = db_action(r_sync2 == r_db, i_tick, r_cnt == CW'(STABLE_TICKS - 1));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_cnt <= '0;
            r_db  <= 1'b0;
        end else begin
            unique case (w_act)
                ACT_CLEAR: r_cnt <= '0;
                ACT_HOLD:  r_cnt <= r_cnt;
                ACT_COUNT: r_cnt <= r_cnt + CW'(1);
                ACT_FLIP: begin
                    r_cnt <= '0;
                    r_db  <= r_sync2;
                end
                default:   r_cnt <= '0;
            endcase
        end
    end

    assign o_db = r_db;

`ifdef MFP_DEBOUNCE_EDGE_EN
    logic r_rise;
    logic r_fall;

    // Registered alongside r_db so each pulse coincides with the new level.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= (w_act == ACT_FLIP) &&  r_sync2;
            r_fall <= (w_act == ACT_FLIP) && !r_sync2;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;
`else
    assign o_rise = 1'b0;
    assign o_fall = 1'b0;
`endif

endmodule

// File: rtl/mfp_io_debounce.sv
// Debouncer for board switches/pushbuttons: shared sample prescaler feeding N bit debouncers.
// Edge pulse outputs are live only with MFP_DEBOUNCE_EDGE_EN defined, otherwise tied 0.
module mfp_io_debounce
    import mfp_io_debounce_pkg::*;
#(
    parameter int unsigned N            = MFP_N_SW + MFP_N_PB,
    parameter int unsigned TICK_DIV     = MFP_DEBOUNCE_TICK_DIV,
    parameter int unsigned STABLE_TICKS = MFP_DEBOUNCE_STABLE
) (
    input  logic         HCLK,
    input  logic         HRESETn,
    input  logic [N-1:0] raw_in,
    output logic [N-1:0] db_out,
    output logic [N-1:0] rise_pulse,
    output logic [N-1:0] fall_pulse,
    output logic         tick
);

    localparam int unsigned DW = $clog2(TICK_DIV);

    logic [DW-1:0] r_div;
    logic          r_tick;

    // Tick is decoded one count early so the registered strobe lines up with div==TICK_DIV-1.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_div  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_div  <= (r_div == DW'(TICK_DIV - 1)) ? '0 : r_div + DW'(1);
            r_tick <= (r_div == DW'(TICK_DIV - 2));
        end
    end

    assign tick = r_tick;

    for (genvar g = 0; g < N; g++) begin : g_bit
        mfp_debounce_bit #(
            .STABLE_TICKS (STABLE_TICKS)
        ) u_bit (
            .HCLK    (HCLK),
            .HRESETn (HRESETn),
            .i_tick  (r_tick),
            .i_raw   (raw_in[g]),
            .o_db    (db_out[g]),
            .o_rise  (rise_pulse[g]),
            .o_fall  (fall_pulse[g])
        );
    end

endmodule

// File: tb/tb_mfp_io_debounce.sv
// Directed bench for mfp_io_debounce with an expected-transition scoreboard.
// Pulse expectations follow MFP_DEBOUNCE_EDGE_EN as compiled.
module tb_mfp_io_debounce;

    localparam int N  = 4;
    localparam int TD = 4;
    localparam int ST = 3;
    localparam int LO = (ST - 1) * TD + 3;
    localparam int HI = ST * TD + 2;
`ifdef MFP_DEBOUNCE_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic         HCLK = 1'b0;
    logic         HRESETn;
    logic [N-1:0] raw_in;
    logic [N-1:0] db_out;
    logic [N-1:0] rise_pulse;
    logic [N-1:0] fall_pulse;
    logic         tick;

    typedef struct packed {
        logic [N-1:0] db;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 HCLK = ~HCLK;

    mfp_io_debounce #(
        .N            (N),
        .TICK_DIV     (TD),
        .STABLE_TICKS (ST)
    ) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .raw_in     (raw_in),
        .db_out     (db_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .tick       (tick)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [N-1:0] db, input logic [N-1:0] r, input logic [N-1:0] f);
        exp_t e;
        e.db   = db;
        e.rise = EDGE ? r : '0;
        e.fall = EDGE ? f : '0;
        sb.push_back(e);
    endtask

    // Wait (bounded) for the next db/pulse change, then pop and compare.
    task automatic wait_evt(input string tag, input int lo, input int hi);
        logic [N-1:0] prev;
        int           cyc;
        exp_t         e;
        prev = db_out;
        cyc  = 0;
        while (db_out === prev && (rise_pulse | fall_pulse) === '0 && cyc <= hi) begin
            @(negedge HCLK);
            cyc++;
        end
        chk({tag, "_latency_in_window"}, 32'(cyc >= lo && cyc <= hi), 32'd1);
        if (sb.size() == 0) begin
            chk({tag, "_scoreboard_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_db"},   32'(db_out),     32'(e.db));
            chk({tag, "_rise"}, 32'(rise_pulse), 32'(e.rise));
            chk({tag, "_fall"}, 32'(fall_pulse), 32'(e.fall));
            @(negedge HCLK);
            chk({tag, "_rise_1cyc"}, 32'(rise_pulse), 32'd0);
            chk({tag, "_fall_1cyc"}, 32'(fall_pulse), 32'd0);
            chk({tag, "_db_held"},   32'(db_out),     32'(e.db));
        end
    endtask

    // Over a window: db must not move and no pulse may appear.
    task automatic quiet(input string tag, input int cycles);
        logic [N-1:0] prev;
        logic [N-1:0] racc;
        logic [N-1:0] facc;
        logic         moved;
        prev  = db_out;
        racc  = '0;
        facc  = '0;
        moved = 1'b0;
        repeat (cycles) begin
            @(negedge HCLK);
            if (db_out !== prev) moved = 1'b1;
            racc |= rise_pulse;
            facc |= fall_pulse;
        end
        chk({tag, "_db_moved"}, 32'(moved), 32'd0);
        chk({tag, "_rise"},     32'(racc),  32'd0);
        chk({tag, "_fall"},     32'(facc),  32'd0);
    endtask

    task automatic do_reset(input logic [N-1:0] raw);
        HRESETn = 1'b0;
        raw_in  = raw;
        repeat (3) @(negedge HCLK);
        HRESETn = 1'b1;
    endtask

    initial begin
        int ticks;
        int waited;

        // 1: inputs high through reset
        HRESETn = 1'b0;
        raw_in  = 4'hF;
        repeat (3) @(negedge HCLK);
        chk("rst_db",   32'(db_out),     32'd0);
        chk("rst_rise", 32'(rise_pulse), 32'd0);
        chk("rst_fall", 32'(fall_pulse), 32'd0);
        chk("rst_tick", 32'(tick),       32'd0);
        HRESETn = 1'b1;
        push(4'hF, 4'hF, 4'h0);
        wait_evt("reset_release", LO, HI);

        ticks = 0;
        repeat (4 * TD) begin
            @(negedge HCLK);
            if (tick === 1'b1) ticks++;
        end
        chk("tick_rate", 32'(ticks), 32'd4);

        // 2: clean edge
        do_reset(4'h0);
        repeat (5) @(negedge HCLK);
        raw_in[0] = 1'b1;
        push(4'b0001, 4'b0001, 4'b0000);
        wait_evt("clean_edge", LO, HI);

        // 3: bounce every 5 cycles for 40 cycles, then hold
        for (int k = 0; k < 8; k++) begin
            raw_in[1] = ~raw_in[1];
            quiet("bounce", 5);
        end
        raw_in[1] = 1'b1;
        push(4'b0011, 4'b0010, 4'b0000);
        wait_evt("bounce_hold", LO, HI);

        // 4: single-cycle glitch at every prescaler phase
        for (int p = 0; p < TD; p++) begin
            repeat (p) @(negedge HCLK);
            raw_in[2] = 1'b1;
            @(negedge HCLK);
            raw_in[2] = 1'b0;
            quiet("glitch", 16);
        end

        // 5: simultaneous flips
        raw_in = 4'b1000;
        push(4'b1000, 4'b1000, 4'b0011);
        wait_evt("to_1000", LO, HI);
        raw_in = 4'b0001;
        push(4'b0001, 4'b0001, 4'b1000);
        wait_evt("simultaneous", LO, HI);

        // 6: reset in the middle of a count
        raw_in = 4'b0000;
        ticks  = 0;
        waited = 0;
        while (ticks < 2 && waited < 20) begin
            @(negedge HCLK);
            waited++;
            if (tick === 1'b1) ticks++;
        end
        chk("midrst_two_ticks", 32'(ticks), 32'd2);
        chk("midrst_db_before", 32'(db_out), 32'b0001);
        HRESETn = 1'b0;
        #1;
        chk("midrst_db",   32'(db_out),     32'd0);
        chk("midrst_rise", 32'(rise_pulse), 32'd0);
        chk("midrst_fall", 32'(fall_pulse), 32'd0);
        chk("midrst_tick", 32'(tick),       32'd0);
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        quiet("post_release", 20);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
